sal_ref_gen: RTL and testbench
==============================

// Module: sal_ref_gen
// PURPOSE
//  Per-bank auto-refresh request generator; sits directly upstream of the bank controller's ref_req_i/ref_gnt_o pair.
//  Generates one refresh obligation every tREFI cycles and accumulates owed refreshes as a debt counter.
//  Requests lazily while the bank is idle; forces the request (urgent) once debt reaches a threshold.
//  Postpones up to MAX_POSTPONE refreshes (DDR4 limit 8).
// PARAMETERS
//  REFI_WIDTH     16  width of the tREFI down-counter and t_refi_m1_i
//  DEBT_WIDTH     4   width of the debt counter; must hold MAX_POSTPONE
//  MAX_POSTPONE   8   maximum owed refreshes; debt saturates here
//  URGENT_THRESH  4   debt at/above which the request ignores idle_i; 1 <= URGENT_THRESH <= MAX_POSTPONE
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           synchronous, active-low reset
//  enable_i       in   1           refresh timer enable (low during init/self-refresh)
//  t_refi_m1_i    in   REFI_WIDTH  tREFI-1 in clk cycles; quasi-static
//  idle_i         in   1           no pending request for this bank (~req valid)
//  ref_req_o      out  1           refresh request to bank controller
//  ref_gnt_i      in   1           refresh issued this cycle (bank ctrl ref_gnt_o)
//  ref_urgent_o   out  1           debt >= URGENT_THRESH
//  debt_o         out  DEBT_WIDTH  current owed refresh count
//  overflow_o     out  1           sticky: a tick arrived with debt == MAX_POSTPONE and no grant
// BEHAVIOUR
//  Reset: cnt <= t_refi_m1_i, debt <= 0, state <= S_IDLE, overflow_o <= 0; hence ref_req_o=0, ref_urgent_o=0, debt_o=0.
//  Timer: enable_i=0 -> cnt <= t_refi_m1_i, tick=0.
//   enable_i=1 & cnt!=0 -> cnt <= cnt-1.  enable_i=1 & cnt==0 -> tick=1, cnt <= t_refi_m1_i.
//   Period = t_refi_m1_i+1 cycles; first tick on the (t_refi_m1_i+1)th enabled cycle after enable rises.
//  Grant accept: acc = ref_gnt_i & ref_req_o; ref_gnt_i without ref_req_o is ignored (no decrement).
//  Debt update (registered, same cycle as tick/acc):
//   tick & ~acc -> debt+1, saturating at MAX_POSTPONE; if debt was MAX_POSTPONE, set overflow_o (sticky until reset).
//   ~tick & acc -> debt-1 (acc implies debt>0, never underflows).
//   tick & acc  -> debt unchanged.
//  Debt is still served while enable_i=0; enable_i only stops new ticks.
//  States (decoded from registered debt; next state follows next debt):
//   S_IDLE    debt==0                          -> ref_req_o=0
//   S_PENDING 0<debt<URGENT_THRESH             -> ref_req_o=idle_i (combinational path)
//   S_URGENT  debt>=URGENT_THRESH              -> ref_req_o=1, ref_urgent_o=1
//   Transitions: IDLE->PENDING on tick; PENDING->URGENT when debt reaches URGENT_THRESH;
//   URGENT->PENDING / PENDING->IDLE on acc-driven decrement.
//  ref_req_o holds (no retraction) while in S_URGENT until acc. In S_PENDING it follows idle_i and may drop.
//  ref_urgent_o and debt_o are pure register outputs. ref_req_o is the only output with a combinational input path.
//  Reset mid-operation: debt and pending request discarded; timer restarts full period.
//  Changing t_refi_m1_i takes effect at the next reload.
// TESTING
//  1 t_refi_m1=9, enable from cycle 0, idle_i=1, gnt same cycle as req -> req pulses cycle 10,20,30; debt_o never >1.
//  2 t_refi_m1=9, idle_i=0, no gnt -> debt 1..3 at ticks 1..3, req=0; tick 4 -> debt=4, ref_urgent_o=1, req=1 regardless of idle_i.
//  3 Continue 2 to 9 ticks, no gnt -> debt saturates at 8 on tick 8, tick 9 sets overflow_o=1 and stays 1; debt_o stays 8.
//  4 debt=1 with tick and gnt in the same cycle -> debt stays 1; gnt while debt=0 -> debt stays 0, no underflow.
//  5 debt=3, idle_i toggles 1,0,1 without gnt -> ref_req_o follows 1,0,1 same cycle; enable_i=0 -> no new ticks, debt drains via gnts to 0.
//  6 Assert rst_n=0 for 1 cycle with debt=5 -> next cycle debt_o=0, req=0, urgent=0; next tick after t_refi_m1+1 cycles.

Source files
------------

// File: rtl/sal_ref_gen.sv
// ----------------------------------------------------------------------------
// sal_ref_gen
//
// Per-bank auto-refresh request generator. A tREFI down-counter produces one
// refresh obligation ("tick") per period. Owed refreshes accumulate in a debt
// counter. The request is raised lazily while the bank is idle. Once the debt
// reaches URGENT_THRESH, the request is forced and held until it is granted.
// The debt saturates at MAX_POSTPONE. A tick that arrives at saturation
// without a grant sets a sticky overflow flag.
//
// Ports
//   clk            clock
//   rst_n          synchronous, active-low reset
//   enable_i       refresh timer enable (low during init / self-refresh)
//   t_refi_m1_i    tREFI-1 in clk cycles, sampled at every timer reload
//   idle_i         bank has no pending request of its own
//   ref_req_o      refresh request to the bank controller
//   ref_gnt_i      refresh issued this cycle by the bank controller
//   ref_urgent_o   debt >= URGENT_THRESH (registered)
//   debt_o         current owed refresh count (registered)
//   overflow_o     sticky: a refresh obligation was lost at saturation
// ----------------------------------------------------------------------------
module sal_ref_gen #(
  parameter int REFI_WIDTH    = 16,
  parameter int DEBT_WIDTH    = 4,
  parameter int MAX_POSTPONE  = 8,
  parameter int URGENT_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [REFI_WIDTH-1:0] t_refi_m1_i,
  input  logic                  idle_i,
  output logic                  ref_req_o,
  input  logic                  ref_gnt_i,
  output logic                  ref_urgent_o,
  output logic [DEBT_WIDTH-1:0] debt_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_URGENT  = 2'd2
  } state_t;

  localparam logic [DEBT_WIDTH-1:0] MAX_DEBT = DEBT_WIDTH'(MAX_POSTPONE);
  localparam logic [DEBT_WIDTH-1:0] URG_DEBT = DEBT_WIDTH'(URGENT_THRESH);
  localparam logic [DEBT_WIDTH-1:0] ONE      = DEBT_WIDTH'(1);

  logic [REFI_WIDTH-1:0] cnt;
  logic [DEBT_WIDTH-1:0] debt;
  logic [DEBT_WIDTH-1:0] debt_nxt;
  state_t                state;
  state_t                state_nxt;
  logic                  urgent;
  logic                  overflow;
  logic                  ovf_set;
  logic                  tick;
  logic                  acc;

  // One obligation per period. The tick fires in the cycle that sees cnt == 0,
  // so the period is t_refi_m1_i + 1 enabled cycles.
  assign tick = enable_i && (cnt == '0);

  // A grant counts only when a request was actually presented. This keeps the
  // debt from underflowing on a stray grant.
  assign acc = ref_gnt_i && ref_req_o;

  // Only output with a combinational input path. In PENDING the request
  // follows idle_i and may drop. In URGENT it holds regardless of idle_i.
  assign ref_req_o = (state == S_URGENT) || ((state == S_PENDING) && idle_i);

  // NOTE: always_comb assigns every output a default first, so no path through
  // the if/else can leave a signal unassigned and infer a latch.
  always_comb begin
    debt_nxt = debt;
    ovf_set  = 1'b0;
    if (tick && !acc) begin
      if (debt == MAX_DEBT) begin
        ovf_set = 1'b1;
      end else begin
        debt_nxt = debt + ONE;
      end
    end else if (!tick && acc) begin
      debt_nxt = debt - ONE;
    end
    // When a tick and an accepted grant coincide, the debt stays unchanged.
  end

  // The state is a pure function of the debt. Deriving it from the next debt
  // keeps the state register and the debt register in lockstep.
  always_comb begin
    if (debt_nxt == '0) begin
      state_nxt = S_IDLE;
    end else if (debt_nxt >= URG_DEBT) begin
      state_nxt = S_URGENT;
    end else begin
      state_nxt = S_PENDING;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= t_refi_m1_i;
      debt     <= '0;
      state    <= S_IDLE;
      urgent   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Disable reloads the counter, so re-enabling starts a full period.
      if (!enable_i || (cnt == '0)) begin
        cnt <= t_refi_m1_i;
      end else begin
        cnt <= cnt - 1'b1;
      end
      debt   <= debt_nxt;
      state  <= state_nxt;
      urgent <= (state_nxt == S_URGENT);
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ref_urgent_o = urgent;
  assign debt_o       = debt;
  assign overflow_o   = overflow;

endmodule

// File: tb/tb_sal_ref_gen.sv
// ----------------------------------------------------------------------------
// tb_sal_ref_gen
//
// Self-checking bench for sal_ref_gen with t_refi_m1 = 9 (period of 10 cycles).
// The stimulus process drives one cycle at a time and queues the outputs
// expected in that cycle. A monitor process pops each entry at the falling
// edge and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_sal_ref_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] t_refi_m1;
  logic        idle;
  logic        ref_req;
  logic        ref_gnt;
  logic        ref_urgent;
  logic [3:0]  debt;
  logic        overflow;

  always #5 clk = ~clk;

  sal_ref_gen #(
    .REFI_WIDTH   (16),
    .DEBT_WIDTH   (4),
    .MAX_POSTPONE (8),
    .URGENT_THRESH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .t_refi_m1_i (t_refi_m1),
    .idle_i      (idle),
    .ref_req_o   (ref_req),
    .ref_gnt_i   (ref_gnt),
    .ref_urgent_o(ref_urgent),
    .debt_o      (debt),
    .overflow_o  (overflow)
  );

  typedef struct {
    logic       req;
    logic       urg;
    logic [3:0] debt;
    logic       ovf;
    string      name;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  // Monitor: compare queued expectations away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".req"},  e.cyc, 32'(ref_req),    32'(e.req));
        check({e.name, ".urg"},  e.cyc, 32'(ref_urgent), 32'(e.urg));
        check({e.name, ".debt"}, e.cyc, 32'(debt),       32'(e.debt));
        check({e.name, ".ovf"},  e.cyc, 32'(overflow),   32'(e.ovf));
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic drive(input logic en, input logic id, input logic gnt,
                       input logic x_req, input logic x_urg,
                       input int x_debt, input logic x_ovf, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst_n   = 1'b1;
    enable  = en;
    idle    = id;
    ref_gnt = gnt;
    e.req   = x_req;
    e.urg   = x_urg;
    e.debt  = 4'(x_debt);
    e.ovf   = x_ovf;
    e.name  = nm;
    e.cyc   = cyc;
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic en, input logic id, input logic gnt,
                     input logic x_req, input logic x_urg, input int x_debt,
                     input logic x_ovf, input string nm);
    for (int i = 0; i < n; i++) drive(en, id, gnt, x_req, x_urg, x_debt, x_ovf, nm);
  endtask

  // A single cycle with rst_n low. Nothing is checked during that cycle.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    idle      = 1'b0;
    ref_gnt   = 1'b0;
    t_refi_m1 = 16'd9;

    // 1: lazy request is granted as soon as it appears. Grant is held high
    //    throughout and must be ignored while nothing is requested.
    do_reset();
    run(10, 1, 1, 1, 0, 0, 0, 0, "t1_first_period");
    for (int p = 0; p < 3; p++) begin
      drive(1, 1, 1, 1, 0, 1, 0, "t1_pulse");
      run(9, 1, 1, 1, 0, 0, 0, 0, "t1_gap");
    end

    // 2/3: no grants, bank busy. Debt climbs 1..3 with no request. Urgent
    //      from 4 on, with the request ignoring a toggling idle. The debt
    //      saturates at 8, and the 9th tick sets a sticky overflow.
    do_reset();
    run(10, 1, 0, 0, 0, 0, 0, 0, "t2_reset_state");
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < 10; i++) begin
        drive(1, (k >= 4) && i[0], 0, k >= 4, k >= 4, (k > 8) ? 8 : k, k >= 9,
              "t23_accumulate");
      end
    end

    // 6: reset with debt=5 discards everything. The timer restarts a full period.
    do_reset();
    run(10, 1, 0, 0, 0, 0, 0, 0, "t6_build0");
    for (int k = 1; k <= 4; k++) run(10, 1, 0, 0, k >= 4, k >= 4, k, 0, "t6_build");
    run(3, 1, 0, 0, 1, 1, 5, 0, "t6_debt5");
    do_reset();
    run(10, 1, 0, 0, 0, 0, 0, 0, "t6_after_reset");
    drive(1, 0, 0, 0, 0, 1, 0, "t6_first_tick");

    // 4: a grant at debt=0 does not underflow. A tick and a grant in the same
    //    cycle leave debt at 1.
    do_reset();
    run(10, 1, 1, 1, 0, 0, 0, 0, "t4_gnt_at_zero");
    run(9, 1, 0, 0, 0, 0, 1, 0, "t4_debt1");
    drive(1, 1, 1, 1, 0, 1, 0, "t4_tick_and_gnt");
    run(10, 1, 0, 0, 0, 0, 1, 0, "t4_hold1");
    run(10, 1, 0, 0, 0, 0, 2, 0, "t5_debt2");

    // 5: in PENDING the request follows idle in the same cycle. With the
    //    timer disabled, the debt drains through grants and no tick appears.
    drive(1, 1, 0, 1, 0, 3, 0, "t5_idle1");
    drive(1, 0, 0, 0, 0, 3, 0, "t5_idle0");
    drive(1, 1, 0, 1, 0, 3, 0, "t5_idle1b");
    drive(0, 1, 1, 1, 0, 3, 0, "t5_drain3");
    drive(0, 1, 1, 1, 0, 2, 0, "t5_drain2");
    drive(0, 1, 1, 1, 0, 1, 0, "t5_drain1");
    run(14, 0, 1, 1, 0, 0, 0, 0, "t5_disabled");
    run(10, 1, 1, 0, 0, 0, 0, 0, "t5_reenable");
    drive(1, 1, 0, 1, 0, 1, 0, "t5_first_tick");

    // Let the monitor consume everything still queued, within a bound.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
